tdm_demux: RTL and testbench
============================

# tdm_demux

Time-division demultiplexer: the receive end of a serial link fed by a 4:1-style mux that sweeps its select across slots 0..WIDTH-1. It locks to a frame-start marker, steers each valid serial bit into the output bit position equal to its slot number, and presents the rebuilt parallel word with a one-cycle valid pulse. It sits after the mux/serialiser and restores the original `in` vector, so that slot k maps to out[k].

## Interface

- WIDTH, 4: slots per frame and output word width; legal range 2..16.
- SEL_W, $clog2(WIDTH): slot counter width; derived, never overridden.

- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_bit  input  1  serial data bit for the current slot.
- in_valid  input  1  in_bit is valid this cycle; one bit is consumed per cycle with in_valid=1.
- frame_start  input  1  qualifies the current in_bit as slot 0; ignored unless in_valid=1.
- out  output  WIDTH  last complete frame; bit k = bit received in slot k.
- out_valid  output  1  one-cycle pulse when out is updated.
- slot  output  SEL_W  slot index the next accepted bit will fill.
- locked  output  1  1 when the FSM is in RUN.
- sync_err  output  1  one-cycle pulse when frame_start arrives mid-frame.

## Operation

- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values: out=0, out_valid=0, slot=0, locked=0, sync_err=0, partial-word register=0, FSM=IDLE.
- Accept condition: in_valid=1. Cycles with in_valid=0 change nothing except clearing the out_valid/sync_err pulses.
- FSM IDLE (unlocked):
  - Accepted bits without frame_start are discarded.
  - An accept with frame_start=1 stores in_bit at partial[0], sets slot to 1, and moves to RUN.
- FSM RUN:
  - Each accept stores in_bit at partial[slot] and increments slot.
  - An accept at slot=WIDTH-1 loads out with {in_bit, partial[WIDTH-2:0]}, pulses out_valid, wraps slot to 0, and clears partial.
  - frame_start at slot=0 is legal and carries no penalty. After lock, frame_start is optional on later frames.
  - frame_start at slot≠0 (resync):
    - pulse sync_err and discard the partial word; out is not updated and out_valid is not pulsed.
    - the bit is stored as partial[0] and slot becomes 1.
  - RUN never returns to IDLE except through reset.
- Special case WIDTH=2 with a resync on the final slot: the resync rule wins and no word is emitted.
- out holds its value between completions.
- The slot counter wraps modulo WIDTH. WIDTH does not need to be a power of two, so wrap is an explicit compare against WIDTH-1, never a natural overflow.
- Asserting reset mid-frame discards the partial word immediately and returns every output to its reset value. After reset release, the block stays in IDLE until the next frame_start.

## Timing

- All outputs are registered; there are no combinational input-to-output paths.
- Latency: the final slot accepted at rising edge N makes the new out and out_valid=1 visible after edge N. out_valid is low again after edge N+1.
- out_valid can never assert on consecutive cycles, because WIDTH≥2 forces at least 2 accepts per word.
- sync_err asserts for exactly the cycle following the offending edge.
- slot and locked update on the same edge as the accept that changes them.
- Minimum frame period is WIDTH cycles, with in_valid continuously high. Throughput is one bit per clock.

## Test plan

- Basic frame (WIDTH=4): send 1,0,0,1 for slots 0..3 with frame_start on the first bit and in_valid held high → after the 4th edge, out=4'b1001, out_valid=1 for 1 cycle, slot=0, locked=1.
- Gapped valid: the same 1,0,0,1 frame with in_valid low for 2 cycles between every bit → out=4'b1001 is produced only after the 4th accepted bit; slot holds during the gaps; out_valid is never seen early.
- Pre-lock discard: send 3 bits with no frame_start, then frame 0,1,1,0 with frame_start on its first bit → locked=0 for the first 3 bits, then out=4'b0110; the junk bits never appear in out.
- Back-to-back frames without re-marking: frames 1001, 0110, 1111, with frame_start only on the first → out_valid pulses exactly every 4 cycles with out=1001, then 0110, then 1111.
- Resync: after 2 bits of a frame, assert frame_start with bit 1, then send 0,1,0 → sync_err pulses once; no out_valid for the aborted frame; next out=4'b0101.
- Reset mid-frame: pull rst_n low asynchronously, between clock edges, after 2 bits → outputs go to 0 immediately, without waiting for an edge; after release, bits without frame_start are ignored, and a full marked frame 1001 yields out=4'b1001.

Source files
------------

// File: rtl/tdm_demux.sv
// rtl/tdm_demux.sv - serial-to-parallel TDM demultiplexer locked to a frame-start marker
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_bit      serial data bit for the current slot
//   in_valid    in_bit is valid and is consumed this cycle
//   frame_start marks the current valid bit as slot 0
//   out         last completed frame, bit k = bit received in slot k
//   out_valid   one-cycle pulse when out is updated
//   slot        slot index the next accepted bit will fill
//   locked      high once a frame_start has been seen (RUN state)
//   sync_err    one-cycle pulse when frame_start arrives mid-frame
module tdm_demux #(
    parameter int WIDTH = 4,
    parameter int SEL_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_bit,
    input  logic             in_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic [SEL_W-1:0] slot,
    output logic             locked,
    output logic             sync_err
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] partial_q, partial_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] slot_q, slot_d;
    logic             sync_err_q, sync_err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            partial_q   <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            slot_q      <= '0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            partial_q   <= partial_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            slot_q      <= slot_d;
            sync_err_q  <= sync_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        partial_d   = partial_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        slot_d      = slot_q;
        sync_err_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Unlocked: everything except a marked bit is dropped.
                if (in_valid && frame_start) begin
                    partial_d    = '0;
                    partial_d[0] = in_bit;
                    slot_d       = SEL_W'(1);
                    state_d      = ST_RUN;
                end
            end
            ST_RUN: begin
                if (in_valid) begin
                    if (frame_start && (slot_q != '0)) begin
                        // Resync takes priority even on the final slot:
                        // the partial word is thrown away, never emitted.
                        sync_err_d   = 1'b1;
                        partial_d    = '0;
                        partial_d[0] = in_bit;
                        slot_d       = SEL_W'(1);
                    end else if (slot_q == LAST_SLOT) begin
                        out_d       = {in_bit, partial_q[WIDTH-2:0]};
                        out_valid_d = 1'b1;
                        partial_d   = '0;
                        slot_d      = '0;
                    end else begin
                        partial_d[slot_q] = in_bit;
                        slot_d            = slot_q + SEL_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign slot      = slot_q;
    assign locked    = (state_q == ST_RUN);
    assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_tdm_demux.sv
// tb/tb_tdm_demux.sv - scoreboard testbench for tdm_demux
module tb_tdm_demux;

    localparam int WIDTH = 4;
    localparam int SEL_W = 2;

    logic             clk;
    logic             rst_n;
    logic             in_bit;
    logic             in_valid;
    logic             frame_start;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic [SEL_W-1:0] slot;
    logic             locked;
    logic             sync_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int nvalid   = 0;
    int sync_cnt = 0;
    logic prev_valid = 1'b0;

    logic [WIDTH-1:0] exp_q[$];
    int               vcyc_q[$];

    tdm_demux #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_bit     (in_bit),
        .in_valid   (in_valid),
        .frame_start(frame_start),
        .out        (out),
        .out_valid  (out_valid),
        .slot       (slot),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a word.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                nvalid++;
                vcyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out_valid: got out=%0h expected no word", out);
                end else begin
                    check("out_word", 32'(out), 32'(exp_q.pop_front()));
                end
                if (prev_valid) begin
                    checks++;
                    failures++;
                    $display("FAIL out_valid_consecutive: got 2 cycles expected 1");
                end
            end
            if (sync_err) sync_cnt++;
        end
        prev_valid = out_valid;
    end

    task automatic send(input logic b, input logic fs);
        in_valid    = 1'b1;
        in_bit      = b;
        frame_start = fs;
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        frame_start = 1'b0;
        in_bit      = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int base;
        rst_n       = 1'b0;
        in_bit      = 1'b0;
        in_valid    = 1'b0;
        frame_start = 1'b0;
        #12;
        check("rst_out", 32'(out), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_slot", 32'(slot), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_sync_err", 32'(sync_err), 0);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Pre-lock discard, then frame 0,1,1,0
        for (int i = 0; i < 3; i++) begin
            send(1'b1, 1'b0);
            check("prelock_locked", 32'(locked), 0);
            check("prelock_slot", 32'(slot), 0);
        end
        send(1'b0, 1'b1);
        check("lock_locked", 32'(locked), 1);
        check("lock_slot", 32'(slot), 1);
        send(1'b1, 1'b0);
        send(1'b1, 1'b0);
        exp_q.push_back(4'b0110);
        send(1'b0, 1'b0);
        check("prelock_done_slot", 32'(slot), 0);
        idle(1);

        // Basic frame 1,0,0,1 (marked frame_start at slot 0 is legal)
        send(1'b1, 1'b1);
        send(1'b0, 1'b0);
        send(1'b0, 1'b0);
        exp_q.push_back(4'b1001);
        send(1'b1, 1'b0);
        check("basic_slot", 32'(slot), 0);
        check("basic_locked", 32'(locked), 1);
        check("basic_sync_err", 32'(sync_err), 0);
        idle(1);
        check("basic_out_hold", 32'(out), 32'h9);

        // Gapped valid
        send(1'b1, 1'b1);
        idle(2);
        check("gap_slot_hold1", 32'(slot), 1);
        send(1'b0, 1'b0);
        idle(2);
        check("gap_slot_hold2", 32'(slot), 2);
        send(1'b0, 1'b0);
        idle(2);
        check("gap_slot_hold3", 32'(slot), 3);
        exp_q.push_back(4'b1001);
        send(1'b1, 1'b0);
        idle(1);

        // Back-to-back frames, frame_start only on the first
        base = vcyc_q.size();
        send(1'b1, 1'b1); send(1'b0, 1'b0); send(1'b0, 1'b0);
        exp_q.push_back(4'b1001); send(1'b1, 1'b0);
        send(1'b0, 1'b0); send(1'b1, 1'b0); send(1'b1, 1'b0);
        exp_q.push_back(4'b0110); send(1'b0, 1'b0);
        send(1'b1, 1'b0); send(1'b1, 1'b0); send(1'b1, 1'b0);
        exp_q.push_back(4'b1111); send(1'b1, 1'b0);
        idle(2);
        check("b2b_count", 32'(vcyc_q.size() - base), 3);
        if (vcyc_q.size() - base == 3) begin
            check("b2b_period1", 32'(vcyc_q[base+1] - vcyc_q[base]), 4);
            check("b2b_period2", 32'(vcyc_q[base+2] - vcyc_q[base+1]), 4);
        end

        // Resync after 2 bits
        send(1'b1, 1'b1);
        send(1'b1, 1'b0);
        send(1'b1, 1'b1);
        check("resync_sync_err", 32'(sync_err), 1);
        check("resync_slot", 32'(slot), 1);
        send(1'b0, 1'b0);
        check("resync_err_clear", 32'(sync_err), 0);
        send(1'b1, 1'b0);
        exp_q.push_back(4'b0101);
        send(1'b0, 1'b0);
        idle(1);
        check("resync_err_count", 32'(sync_cnt), 1);

        // Asynchronous reset mid-frame
        send(1'b1, 1'b1);
        send(1'b1, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_out", 32'(out), 0);
        check("async_rst_slot", 32'(slot), 0);
        check("async_rst_locked", 32'(locked), 0);
        check("async_rst_valid", 32'(out_valid), 0);
        #2 rst_n = 1'b1;
        send(1'b1, 1'b0);
        send(1'b1, 1'b0);
        check("post_rst_locked", 32'(locked), 0);
        check("post_rst_slot", 32'(slot), 0);
        send(1'b1, 1'b1); send(1'b0, 1'b0); send(1'b0, 1'b0);
        exp_q.push_back(4'b1001);
        send(1'b1, 1'b0);
        idle(2);

        check("scoreboard_empty", 32'(exp_q.size()), 0);
        check("total_words", 32'(nvalid), 8);
        check("total_sync_err", 32'(sync_cnt), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no finish expected finish before 50000");
        $fatal(1);
    end

endmodule
